// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   - uart_tx_state_t : transmitter FSM state
//   - UART_*          : register offsets within the 16-byte window
//   - STATUS_*/CTRL_* : bit positions inside STATUS and CTRL
//   - F3_*            : RV32 load/store width codes (funct3)
//   - load_extend     : applies RV32 load sign/zero extension to a register word
//   - store_size      : trims store data to the width named by funct3
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;
  localparam logic [3:0] UART_CTRL    = 4'hC;

  localparam int unsigned STATUS_FULL      = 0;
  localparam int unsigned STATUS_EMPTY     = 1;
  localparam int unsigned STATUS_BUSY      = 2;
  localparam int unsigned STATUS_OVERFLOW  = 3;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W   = 4;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_CLR_OVF = 2;
  localparam int unsigned CTRL_FLUSH   = 3;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3);
    logic [31:0] result;
    case (funct3)
      F3_BYTE:   result = {{24{word[7]}}, word[7:0]};
      F3_HALF:   result = {{16{word[15]}}, word[15:0]};
      F3_WORD:   result = word;
      F3_BYTE_U: result = {24'h0, word[7:0]};
      F3_HALF_U: result = {16'h0, word[15:0]};
      default:   result = '0;
    endcase
    return result;
  endfunction

  // Stores only distinguish byte / half / word by funct3[1:0].
  function automatic logic [31:0] store_size(input logic [31:0] data,
                                             input logic [2:0]  funct3);
    logic [31:0] result;
    case (funct3[1:0])
      2'b00:   result = {24'h0, data[7:0]};
      2'b01:   result = {16'h0, data[15:0]};
      default: result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO for the UART transmit path.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data
//   pop, dout    : read request and head-of-queue data (valid while !empty)
//   flush        : empties the FIFO; wins over a same-cycle push
//   full, empty  : occupancy flags
//   count        : number of stored entries
// A push while full is accepted when a pop happens in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data bus.
//   clk, reset_n         : clock, asynchronous active-low reset
//   write_mem, funct3    : store strobe and RV32 width code (funct3 also sets load extension)
//   write_address/data   : store address and data
//   read_address         : load address
//   read_data            : registered load data, 0 outside the window
//   tx                   : serial line, idle high
//   irq                  : irq_en & FIFO empty & transmitter idle
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R), 0x8 BAUDDIV (R/W), 0xC CTRL (R/W).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] RESET_DIV  = 16'd104
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Control / status registers
  logic        enable;
  logic        irq_en;
  logic        overflow;
  logic [15:0] baud_div;

  // FIFO interface
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Transmitter
  uart_tx_state_t state;
  logic [7:0]     shift;
  logic [2:0]     bit_idx;
  logic [15:0]    baud_cnt;
  logic [15:0]    frame_div;
  logic           bit_end;
  logic           busy;

  // Store decode
  logic        wr_hit;
  logic [3:0]  wr_off;
  logic [31:0] wr_val;
  logic        txdata_wr;
  logic        baud_wr;
  logic        ctrl_wr;

  assign wr_hit    = write_mem
                  && (write_address[31:4] == BASE_ADDR[31:4])
                  && (write_address[1:0] == 2'b00);
  assign wr_off    = {write_address[3:2], 2'b00};
  assign wr_val    = store_size(write_data, funct3);
  assign txdata_wr = wr_hit && (wr_off == UART_TXDATA);
  assign baud_wr   = wr_hit && (wr_off == UART_BAUDDIV);
  assign ctrl_wr   = wr_hit && (wr_off == UART_CTRL);

  assign fifo_push  = txdata_wr;
  assign fifo_flush = ctrl_wr && wr_val[CTRL_FLUSH];

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (wr_val[7:0]),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      baud_div <= RESET_DIV;
    end else begin
      if (baud_wr) begin
        baud_div <= (wr_val[15:0] == 16'd0) ? 16'd1 : wr_val[15:0];
      end
      if (ctrl_wr) begin
        enable <= wr_val[CTRL_ENABLE];
        irq_en <= wr_val[CTRL_IRQ_EN];
      end
      // A push lost to a flush is discarded silently, not counted as overflow.
      if (ctrl_wr && wr_val[CTRL_CLR_OVF]) begin
        overflow <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) begin
        overflow <= 1'b1;
      end
    end
  end

  // A frame starts from IDLE, or straight out of the last STOP cycle so that
  // queued bytes go out back-to-back.
  assign bit_end  = (baud_cnt == 16'd0);
  assign busy     = (state != IDLE);
  assign fifo_pop = enable && !fifo_empty
                 && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      frame_div <= '0;
      tx        <= 1'b1;
    end else if (fifo_pop) begin
      state     <= START;
      tx        <= 1'b0;
      shift     <= fifo_dout;
      bit_idx   <= '0;
      frame_div <= baud_div;
      baud_cnt  <= baud_div - 16'd1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= '0;
            baud_cnt <= frame_div - 16'd1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= frame_div - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign irq = irq_en && fifo_empty && !busy;

  // Load path
  logic        rd_hit;
  logic [31:0] status_word;
  logic [31:0] rd_word;

  assign rd_hit = (read_address[31:4] == BASE_ADDR[31:4])
               && (read_address[1:0] == 2'b00);

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_FULL]     = fifo_full;
    status_word[STATUS_EMPTY]    = fifo_empty;
    status_word[STATUS_BUSY]     = busy;
    status_word[STATUS_OVERFLOW] = overflow;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  always_comb begin
    rd_word = '0;
    case (read_address[3:0])
      UART_STATUS:  rd_word = status_word;
      UART_BAUDDIV: rd_word = {16'h0, baud_div};
      UART_CTRL: begin
        rd_word[CTRL_ENABLE] = enable;
        rd_word[CTRL_IRQ_EN] = irq_en;
      end
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= '0;
    end else begin
      read_data <= rd_hit ? load_extend(rd_word, funct3) : '0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_mem = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_address = '0;
  logic [31:0] read_data;
  logic        tx;
  logic        irq;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .RESET_DIV  (16'd104)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .tx            (tx),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and the queue of bytes awaiting transmission.
  byte unsigned      m_q[$];
  bit                m_ovf, m_en, m_ien, m_busy;
  longint unsigned   m_div;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_en = 0; m_ien = 0; m_busy = 0; m_div = 104;
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) <= 32'd15) && ((a % 4) == 0);
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    longint unsigned v;
    if (!in_window(a)) return;
    if (f3 % 4 == 0)      v = d % 256;
    else if (f3 % 4 == 1) v = d % 65536;
    else                  v = d;
    case ((a - BASE) / 4)
      0: if (m_q.size() < 8) m_q.push_back(byte'(v % 256)); else m_ovf = 1;
      2: m_div = (v % 65536 == 0) ? 1 : v % 65536;
      3: begin
        m_en  = (v & 1) != 0;
        m_ien = (v & 2) != 0;
        if ((v & 4) != 0) m_ovf = 0;
        if ((v & 8) != 0) m_q.delete();
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [2:0] f3);
    longint unsigned w;
    int n;
    n = m_q.size();
    if (!in_window(a)) return 32'h0;
    w = 0;
    case ((a - BASE) / 4)
      1: begin
        if (n == 8) w += 1;
        if (n == 0) w += 2;
        if (m_busy) w += 4;
        if (m_ovf)  w += 8;
        w += 256 * longint'(n);
      end
      2: w = m_div;
      3: begin
        if (m_en)  w += 1;
        if (m_ien) w += 2;
      end
      default: w = 0;
    endcase
    case (f3)
      3'b000: return (w % 256 >= 128) ? 32'(w % 256 + 64'hFFFF_FF00) : 32'(w % 256);
      3'b001: return (w % 65536 >= 32768) ? 32'(w % 65536 + 64'hFFFF_0000) : 32'(w % 65536);
      3'b010: return 32'(w);
      3'b100: return 32'(w % 256);
      3'b101: return 32'(w % 65536);
      default: return 32'h0;
    endcase
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    write_mem = 1'b1; write_address = a; write_data = d; funct3 = f3;
    @(posedge clk);
    model_wr(a, d, f3);
    @(negedge clk);
    write_mem = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] exp;
    read_address = a; funct3 = f3;
    exp = model_rd(a, f3);
    @(posedge clk);
    @(negedge clk);
    check_eq(tag, read_data, exp);
  endtask

  task automatic wait_start(input string tag, input int limit);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " start"}, 32'(tx), 32'd0);
  endtask

  // Expects the current sample to be the first cycle of a start bit; checks
  // every cycle of the frame: start 0, data LSB first, stop 1, each div long.
  task automatic check_frame(input string tag, input int div);
    int unsigned b, idx, e;
    b = m_q.pop_front();
    m_busy = 1;
    for (int k = 0; k < 10 * div; k++) begin
      idx = k / div;
      if (idx == 0)      e = 0;
      else if (idx == 9) e = 1;
      else               e = (b >> (idx - 1)) & 1;
      check_eq($sformatf("%s byte%02h bit%0d", tag, b, idx), 32'(tx), e);
      check_eq({tag, " irq busy"}, 32'(irq), 32'd0);
      @(negedge clk);
    end
    m_busy = m_en && (m_q.size() > 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned d1, d2;
  logic [31:0] rv;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset tx", 32'(tx), 32'd1);
    check_eq("reset irq", 32'(irq), 32'd0);
    check_eq("reset read_data", read_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    load_check("reset status", BASE + 4, 3'b010);
    load_check("reset bauddiv", BASE + 8, 3'b010);
    load_check("reset ctrl", BASE + 12, 3'b010);

    // Single frame, 4 clocks per bit
    store(BASE + 8, 32'd4, 3'b010);
    store(BASE + 12, 32'd1, 3'b010);
    store(BASE, 32'h0000_0055, 3'b000);
    check_eq("single pre-start tx", 32'(tx), 32'd1);
    @(negedge clk);
    check_frame("single", 4);
    load_check("single status", BASE + 4, 3'b010);

    // Random bytes and divisors; BAUDDIV rewritten mid-frame applies to the next frame
    for (int i = 0; i < 4; i++) begin
      d1 = $urandom_range(1, 5);
      d2 = $urandom_range(1, 5);
      store(BASE + 8, d1, 3'b010);
      store(BASE, $urandom, 3'b000);
      wait_start("rnd", 10);
      fork
        check_frame("rnd", int'(d1));
        begin
          repeat (2) @(negedge clk);
          store(BASE + 8, d2, 3'b010);
        end
      join
      load_check("rnd bauddiv", BASE + 8, 3'b010);
      store(BASE, $urandom, 3'b000);
      wait_start("rnd2", 10);
      check_frame("rnd2", int'(d2));
      load_check("rnd status", BASE + 4, 3'b010);
    end

    // Overflow with transmitter disabled, then drain back-to-back
    store(BASE + 12, 32'd0, 3'b010);
    for (int i = 0; i < 9; i++) store(BASE, $urandom, 3'b000);
    load_check("ovf status", BASE + 4, 3'b010);
    store(BASE + 12, 32'd4, 3'b010);
    load_check("ovf cleared", BASE + 4, 3'b010);
    store(BASE + 8, 32'd2, 3'b010);
    store(BASE + 12, 32'd1, 3'b010);
    wait_start("drain", 10);
    for (int i = 0; i < 8; i++) check_frame($sformatf("drain%0d", i), 2);
    load_check("drain status", BASE + 4, 3'b010);

    // Load widths and address decode
    store(BASE + 8, 32'h1234_56AB, 3'b000);
    load_check("sb bauddiv", BASE + 8, 3'b010);
    store(BASE + 8, 32'hFFFF_8001, 3'b001);
    load_check("lb", BASE + 8, 3'b000);
    load_check("lh", BASE + 8, 3'b001);
    load_check("lhu", BASE + 8, 3'b101);
    load_check("lbu", BASE + 8, 3'b100);
    load_check("lw", BASE + 8, 3'b010);
    load_check("lw past window", BASE + 16, 3'b010);
    load_check("lw unaligned", BASE + 6, 3'b010);
    load_check("lw txdata", BASE, 3'b010);
    store(BASE + 6, 32'h0000_0007, 3'b010);
    store(BASE - 8, 32'h0000_0007, 3'b010);
    store(BASE + 9, 32'h0000_0007, 3'b000);
    load_check("ignored store bauddiv", BASE + 8, 3'b010);
    load_check("ignored store status", BASE + 4, 3'b010);
    store(BASE + 8, 32'hABCD_1234, 3'b010);
    load_check("sw bauddiv", BASE + 8, 3'b010);

    // Clear enable mid-frame, then flush
    store(BASE + 8, 32'd3, 3'b010);
    store(BASE + 12, 32'd0, 3'b010);
    for (int i = 0; i < 4; i++) store(BASE, $urandom, 3'b000);
    store(BASE + 12, 32'd1, 3'b010);
    wait_start("endis", 10);
    fork
      check_frame("endis", 3);
      begin
        repeat (4) @(negedge clk);
        store(BASE + 12, 32'd0, 3'b010);
      end
    join
    for (int i = 0; i < 12; i++) begin
      check_eq("disabled idle tx", 32'(tx), 32'd1);
      @(negedge clk);
    end
    load_check("disabled status", BASE + 4, 3'b010);
    store(BASE + 12, 32'd8, 3'b010);
    load_check("flushed status", BASE + 4, 3'b010);

    // Asynchronous reset in the middle of a data bit
    store(BASE + 12, 32'd1, 3'b010);
    store(BASE, 32'h0000_0000, 3'b000);
    wait_start("rst", 10);
    repeat (5) @(negedge clk);
    check_eq("pre-reset tx", 32'(tx), 32'd0);
    #2 reset_n = 1'b0;
    #1 check_eq("async reset tx", 32'(tx), 32'd1);
    check_eq("async reset irq", 32'(irq), 32'd0);
    check_eq("async reset read_data", read_data, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("post-reset tx", 32'(tx), 32'd1);
      @(negedge clk);
    end
    load_check("post-reset status", BASE + 4, 3'b010);
    load_check("post-reset bauddiv", BASE + 8, 3'b010);
    load_check("post-reset ctrl", BASE + 12, 3'b010);

    // irq, and BAUDDIV=0 stored as 1
    store(BASE + 8, 32'd2, 3'b010);
    store(BASE + 12, 32'd3, 3'b010);
    check_eq("irq idle", 32'(irq), 32'd1);
    store(BASE, $urandom, 3'b000);
    check_eq("irq after push", 32'(irq), 32'd0);
    @(negedge clk);
    check_frame("irq", 2);
    check_eq("irq after stop", 32'(irq), 32'd1);
    store(BASE + 8, 32'd0, 3'b010);
    load_check("bauddiv zero", BASE + 8, 3'b010);
    rv = $urandom;
    store(BASE, rv, 3'b000);
    check_eq("div1 pre-start tx", 32'(tx), 32'd1);
    @(negedge clk);
    check_frame("div1", 1);
    load_check("final status", BASE + 4, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds to the CPU's data-memory bus: the same write_mem/funct3/address/data signals the core drives into main memory.
- Sits beside the memory block in top; the top ORs its read_data with memory read data.
- Buffers CPU-stored bytes in a small FIFO and serialises them 8N1, LSB first, on a single tx pin.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of 2, minimum 2.
- RESET_DIV, 104: baud divisor at reset, in clocks per bit (12 MHz / 115200).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- write_mem  input  1  store strobe from the core
- funct3  input  3  RV32 load/store width code
- write_address  input  32  store address
- write_data  input  32  store data
- read_address  input  32  load address
- read_data  output  32  registered load data; 0 when the address is outside the window
- tx  output  1  serial line, idle high
- irq  output  1  level interrupt: irq_en AND FIFO empty AND NOT busy

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 TXDATA: write pushes write_data[7:0]; reads return 0.
  - 0x4 STATUS (read-only):
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
    - bits[11:8] FIFO count.
  - 0x8 BAUDDIV: read/write, bits[15:0]. A written value of 0 is stored as 1.
  - 0xC CTRL:
    - bit0 enable and bit1 irq_en are read/write.
    - Writing 1 to bit2 clears overflow; writing 1 to bit3 flushes the FIFO. Bits 2 and 3 always read 0.
- Stores:
  - Decoded only when write_mem=1, the address is inside the window and addr[1:0]=00. Any other store is ignored.
  - SB and SH use the low 8/16 bits of write_data; SW uses the full word.
- Loads:
  - read_data is registered with 1-cycle latency, matching memory.
  - Extension follows funct3: 000 sign-extends [7:0], 001 sign-extends [15:0], 010 full word, 100 zero-extends [7:0], 101 zero-extends [15:0].
  - An unaligned or out-of-window address returns 0.
- FIFO push/pop rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A rejected push sets overflow; FIFO contents are unchanged.
  - Flush empties the FIFO; any frame already in progress completes.
  - If flush and push occur in the same cycle, flush wins and the push is discarded without setting overflow.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when enable=1 and FIFO non-empty. The FIFO pops in that cycle and the byte loads into the shift register.
  - tx=0 for the START bit, then 8 data bits LSB first, then tx=1 for one STOP bit.
  - Each bit lasts exactly BAUDDIV clocks, counted by a down-counter reloaded at every bit boundary.
  - BAUDDIV is sampled at frame start; writes during a frame take effect on the next frame.
  - STOP→START directly, with no idle gap, if enable=1 and the FIFO is non-empty; otherwise STOP→IDLE.
  - busy=1 in every state except IDLE.
- Latency: a TXDATA store in cycle N, with the FIFO empty, FSM IDLE and enable=1, gives empty=0 in N+1, pop in N+1, and tx falling edge at N+2.
- Clearing enable mid-frame completes the current frame, then stops in IDLE; no further pops occur.
- Reset values (asynchronous, in effect immediately, including mid-frame):
  - tx=1, read_data=0, irq=0.
  - FSM in IDLE, FIFO empty, overflow=0, enable=0, irq_en=0, BAUDDIV=RESET_DIV.

Decomposition:
- Package uart_pkg holds:
  - enum uart_tx_state_t {IDLE, START, DATA, STOP};
  - register offset localparams UART_TXDATA, UART_STATUS, UART_BAUDDIV, UART_CTRL;
  - STATUS and CTRL bit-index constants.
- Funct3 load-extension encodings reuse the existing core constants.
- One sub-module: uart_fifo, a synchronous FIFO with push, pop, flush, full, empty and count outputs.

Test Plan:
- Reset: hold reset_n=0 -> tx=1, irq=0. A LW at 0x4 then returns 0x0000_0002 (empty); a LW at 0x8 returns 104.
- Single frame: SW 4 to BAUDDIV, SW 1 to CTRL, SB 0x55 to TXDATA -> tx falls 2 cycles after the store. Line reads 0,1,0,1,0,1,0,1,0,1 in 4-cycle bit periods; busy is 1 for 40 cycles; STATUS then reads 0x2.
- Overflow: enable=0, push 9 bytes -> STATUS = 0x0000_0809 (count 8, full, overflow). Writing CTRL 0x4 clears bit3. Then enable=1: exactly 8 frames are sent back-to-back with no idle gap.
- Load width and decode: SB 0xAB and SH 0x8001 to BAUDDIV -> LB at 0x8 returns 0x0000_0001, LH returns 0xFFFF_8001, LHU returns 0x0000_8001. A LW at BASE_ADDR+0x10 and at BASE_ADDR+0x6 each return 0; a store at BASE_ADDR+0x6 changes nothing.
- Enable, flush and reset mid-frame:
  - Clear enable mid-frame -> the current frame finishes and 3 queued bytes remain (count 3).
  - Writing CTRL 0x8 -> count 0.
  - Asserting reset_n=0 mid-bit -> tx=1 in the same cycle, and all registers return to reset values.
- irq and BAUDDIV=0: irq_en=1, enable=1, send one byte -> irq=0 while busy and returns to 1 one cycle after STOP ends. Writing BAUDDIV=0 then reads back 1 and gives 1-clock bit periods.
